// File: rtl/baud_tick_sched.sv
// Runtime-programmable baud scheduler: oversample/bit clock-enable ticks from clk_in, divisor updates via valid/ready.
// Optional half-integer divisors are compiled in with `BAUD_HALF_DIV_EN.
module baud_tick_sched #(
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_DIV  = 434,
  parameter int DEFAULT_HALF = 0,
  parameter int OVS          = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 line_idle,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_half,
  output logic                 cfg_err,
  output logic                 upd_done,
  output logic [DIV_WIDTH-1:0] cur_div,
  output logic                 cur_half,
  output logic                 tick_ovs,
  output logic                 tick_bit
);

  localparam int CW = DIV_WIDTH + 1;
  localparam int OW = $clog2(OVS);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_PEND} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [OW-1:0]        r_ovs_cnt;
  logic [DIV_WIDTH-1:0] r_cur_div;
  logic [DIV_WIDTH-1:0] r_shd_div;
  logic                 r_cfg_ready;
  logic                 r_cfg_err;
  logic                 r_upd_done;
  logic                 r_tick_ovs;
  logic                 r_tick_bit;

  logic          w_extra;
  logic          w_running;
  logic [CW-1:0] w_period;
  logic          w_wrap;
  logic          w_bit_wrap;
  logic          w_accept;
  logic          w_div_ok;
  logic          w_load_cfg;
  logic          w_load_shd;
  logic          w_store_shd;
  logic          w_restart;

  assign w_running  = (r_state != S_OFF);
  assign w_period   = {1'b0, r_cur_div} + CW'(w_extra);
  assign w_wrap     = w_running && (r_cnt == w_period - CW'(1));
  assign w_bit_wrap = w_wrap && (r_ovs_cnt == OW'(OVS - 1));
  assign w_accept   = cfg_valid && r_cfg_ready;
  assign w_div_ok   = (cfg_div >= DIV_WIDTH'(2));
  assign w_restart  = w_load_shd || (w_state_nxt == S_OFF);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) r_state <= S_OFF;
    else      r_state <= w_state_nxt;
  end

  // Disable wins over a same-edge apply, but any pending or just-offered divisor still lands.
  always_comb begin
    w_state_nxt = r_state;
    w_load_cfg  = 1'b0;
    w_load_shd  = 1'b0;
    w_store_shd = 1'b0;
    case (r_state)
      S_OFF: begin
        w_load_cfg = w_accept && w_div_ok;
        if (enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_OFF;
          w_load_cfg  = w_accept && w_div_ok;
        end else if (w_accept && w_div_ok) begin
          w_store_shd = 1'b1;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (!enable) begin
          w_state_nxt = S_OFF;
          w_load_shd  = 1'b1;
        end else if (w_bit_wrap && line_idle) begin
          w_state_nxt = S_RUN;
          w_load_shd  = 1'b1;
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_ovs_cnt   <= '0;
      r_cur_div   <= DIV_WIDTH'(DEFAULT_DIV);
      r_shd_div   <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_upd_done  <= 1'b0;
      r_tick_ovs  <= 1'b0;
      r_tick_bit  <= 1'b0;
    end else begin
      r_cfg_ready <= (w_state_nxt != S_PEND);
      r_cfg_err   <= w_accept && !w_div_ok;
      r_upd_done  <= w_load_cfg || w_load_shd;
      r_tick_ovs  <= w_wrap && (w_state_nxt != S_OFF);
      r_tick_bit  <= w_bit_wrap && (w_state_nxt != S_OFF);
      if (w_load_cfg)      r_cur_div <= cfg_div;
      else if (w_load_shd) r_cur_div <= r_shd_div;
      if (w_store_shd) r_shd_div <= cfg_div;
      if (w_restart) begin
        r_cnt     <= '0;
        r_ovs_cnt <= '0;
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_ovs_cnt <= r_ovs_cnt + OW'(1);
      end else if (w_running) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef BAUD_HALF_DIV_EN
  logic r_cur_half;
  logic r_shd_half;
  logic r_half_phase;

  assign w_extra = r_cur_half && r_half_phase;

  // Phase 0 uses the integer period, so the first interval after any restart is cur_div.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cur_half   <= 1'(DEFAULT_HALF);
      r_shd_half   <= 1'b0;
      r_half_phase <= 1'b0;
    end else begin
      if (w_load_cfg)      r_cur_half <= cfg_half;
      else if (w_load_shd) r_cur_half <= r_shd_half;
      if (w_store_shd) r_shd_half <= cfg_half;
      if (w_restart)   r_half_phase <= 1'b0;
      else if (w_wrap) r_half_phase <= ~r_half_phase;
    end
  end

  assign cur_half = r_cur_half;
`else
  logic w_unused_half;

  assign w_unused_half = cfg_half ^ 1'(DEFAULT_HALF);
  assign w_extra       = 1'b0;
  assign cur_half      = 1'b0;
`endif

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign upd_done  = r_upd_done;
  assign cur_div   = r_cur_div;
  assign tick_ovs  = r_tick_ovs;
  assign tick_bit  = r_tick_bit;

endmodule

// File: tb/tb_baud_tick_sched.sv
// Directed bench for baud_tick_sched: OFF-state config vectors plus tick-spacing and rate-switch sequences.
module tb_baud_tick_sched;

`ifdef BAUD_HALF_DIV_EN
  localparam logic HALF_ON = 1'b1;
`else
  localparam logic HALF_ON = 1'b0;
`endif

  logic        clk_in;
  logic        rst;
  logic        enable;
  logic        line_idle;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic        cfg_half;
  logic        cfg_err;
  logic        upd_done;
  logic [15:0] cur_div;
  logic        cur_half;
  logic        tick_ovs;
  logic        tick_bit;

  int n_tests = 0;
  int n_fail  = 0;

  baud_tick_sched dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .line_idle(line_idle),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_half (cfg_half),
    .cfg_err  (cfg_err),
    .upd_done (upd_done),
    .cur_div  (cur_div),
    .cur_half (cur_half),
    .tick_ovs (tick_ovs),
    .tick_bit (tick_bit)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct {
    logic        en;
    logic        vld;
    logic [15:0] div;
    logic        half;
    logic        e_rdy;
    logic        e_err;
    logic        e_upd;
    logic [15:0] e_cur;
    logic        e_half;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Counts negedges until the selected output is seen high; -1 if the budget runs out.
  task automatic wait_sig(input int sel, input int limit, output int n);
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk_in);
      n++;
      case (sel)
        0:       seen = tick_ovs;
        1:       seen = tick_bit;
        default: seen = upd_done;
      endcase
    end
    if (!seen) n = -1;
  endtask

  task automatic count_sig(input int sel, input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk_in);
      case (sel)
        0:       c += int'(tick_ovs);
        1:       c += int'(tick_bit);
        default: c += int'(upd_done);
      endcase
    end
  endtask

  task automatic sync_sig(input string nm, input int sel, input int limit);
    int n;
    wait_sig(sel, limit, n);
    chk(nm, 32'(n > 0), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_tick_ovs"}, 32'(tick_ovs), 32'd0);
    chk({nm, "_tick_bit"}, 32'(tick_bit), 32'd0);
    chk({nm, "_upd_done"}, 32'(upd_done), 32'd0);
    chk({nm, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({nm, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({nm, "_cur_div"}, 32'(cur_div), 32'd434);
    chk({nm, "_cur_half"}, 32'(cur_half), 32'd0);
  endtask

  // Loads a divisor from OFF and leaves the block enabled with the given line_idle.
  task automatic load_and_run(input logic [15:0] d, input logic idle);
    enable    = 1'b0;
    step(1);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_half  = 1'b0;
    step(1);
    cfg_valid = 1'b0;
    enable    = 1'b1;
    line_idle = idle;
  endtask

  int n;
  int c;

  initial begin
    // en, vld, div, half | rdy, err, upd, cur, cur_half
    vecs[0] = '{1'b0, 1'b1, 16'd1,     1'b0, 1'b1, 1'b1, 1'b0, 16'd434,   1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'd0,     1'b0, 1'b1, 1'b1, 1'b0, 16'd434,   1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 1'b0, 16'd434,   1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'd7,     1'b1, 1'b1, 1'b0, 1'b1, 16'd7,     HALF_ON};
    vecs[4] = '{1'b0, 1'b0, 16'd7,     1'b1, 1'b1, 1'b0, 1'b0, 16'd7,     HALF_ON};
    vecs[5] = '{1'b0, 1'b1, 16'd9,     1'b0, 1'b1, 1'b0, 1'b1, 16'd9,     1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'd2,     1'b0, 1'b1, 1'b0, 1'b1, 16'd2,     1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'hFFFF,  1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF,  HALF_ON};
    vecs[8] = '{1'b0, 1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF,  HALF_ON};

    rst       = 1'b0;
    enable    = 1'b0;
    line_idle = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_half  = 1'b0;
    step(3);
    chk_reset_outputs("rst0");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      enable    = vecs[i].en;
      cfg_valid = vecs[i].vld;
      cfg_div   = vecs[i].div;
      cfg_half  = vecs[i].half;
      step(1);
      chk($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_cfg_err", i), 32'(cfg_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_upd_done", i), 32'(upd_done), 32'(vecs[i].e_upd));
      chk($sformatf("vec%0d_cur_div", i), 32'(cur_div), 32'(vecs[i].e_cur));
      chk($sformatf("vec%0d_cur_half", i), 32'(cur_half), 32'(vecs[i].e_half));
      chk($sformatf("vec%0d_tick_ovs", i), 32'(tick_ovs), 32'd0);
    end
    cfg_valid = 1'b0;

    // T1: defaults after reset with enable held high
    rst    = 1'b0;
    enable = 1'b1;
    #1;
    chk_reset_outputs("t1_in_rst");
    step(2);
    chk("t1_in_rst_tick", 32'(tick_ovs), 32'd0);
    rst = 1'b1;
    wait_sig(0, 1000, n);
    chk("t1_first_ovs", 32'(n), 32'd435);
    wait_sig(0, 1000, n);
    chk("t1_ovs_gap", 32'(n), 32'd434);
    wait_sig(1, 8000, n);
    chk("t1_first_bit", 32'(n), 32'd6076);
    wait_sig(1, 8000, n);
    chk("t1_bit_gap", 32'(n), 32'd6944);

    // T2: divisor 5 with half flag, loaded in OFF
    enable    = 1'b0;
    step(1);
    cfg_valid = 1'b1;
    cfg_div   = 16'd5;
    cfg_half  = 1'b1;
    step(1);
    chk("t2_upd_done", 32'(upd_done), 32'd1);
    chk("t2_cur_div", 32'(cur_div), 32'd5);
    chk("t2_cur_half", 32'(cur_half), 32'(HALF_ON));
    cfg_valid = 1'b0;
    enable    = 1'b1;
    wait_sig(0, 100, n);
    chk("t2_first_ovs", 32'(n), 32'd6);
    for (int k = 0; k < 4; k++) begin
      wait_sig(0, 100, n);
      chk($sformatf("t2_gap%0d", k), 32'(n), (HALF_ON && (k % 2 == 0)) ? 32'd6 : 32'd5);
    end
    sync_sig("t2_bit_seen", 1, 200);
    wait_sig(1, 200, n);
    chk("t2_bit_gap", 32'(n), HALF_ON ? 32'd88 : 32'd80);

    // T3: rate change held in PEND until the line is idle at a bit boundary
    load_and_run(16'd8, 1'b0);
    wait_sig(0, 100, n);
    chk("t3_first_ovs", 32'(n), 32'd9);
    cfg_valid = 1'b1;
    cfg_div   = 16'd12;
    step(1);
    cfg_valid = 1'b0;
    chk("t3_pend_rdy", 32'(cfg_ready), 32'd0);
    chk("t3_pend_cur", 32'(cur_div), 32'd8);
    wait_sig(0, 100, n);
    chk("t3_pend_gap0", 32'(n), 32'd7);
    wait_sig(0, 100, n);
    chk("t3_pend_gap1", 32'(n), 32'd8);
    sync_sig("t3_busy_bit_seen", 1, 300);
    chk("t3_busy_upd", 32'(upd_done), 32'd0);
    chk("t3_busy_cur", 32'(cur_div), 32'd8);
    chk("t3_busy_rdy", 32'(cfg_ready), 32'd0);
    line_idle = 1'b1;
    wait_sig(1, 300, n);
    chk("t3_apply_bit_gap", 32'(n), 32'd128);
    chk("t3_apply_upd", 32'(upd_done), 32'd1);
    chk("t3_apply_cur", 32'(cur_div), 32'd12);
    chk("t3_apply_rdy", 32'(cfg_ready), 32'd1);
    wait_sig(0, 100, n);
    chk("t3_new_gap", 32'(n), 32'd12);
    chk("t3_upd_single", 32'(upd_done), 32'd0);

    // T4: divisors below 2 rejected while running
    cfg_valid = 1'b1;
    cfg_div   = 16'd1;
    step(1);
    chk("t4_err_div1", 32'(cfg_err), 32'd1);
    chk("t4_cur_div1", 32'(cur_div), 32'd12);
    chk("t4_rdy_div1", 32'(cfg_ready), 32'd1);
    cfg_div = 16'd0;
    step(1);
    chk("t4_err_div0", 32'(cfg_err), 32'd1);
    cfg_valid = 1'b0;
    step(1);
    chk("t4_err_clear", 32'(cfg_err), 32'd0);
    chk("t4_rdy", 32'(cfg_ready), 32'd1);
    chk("t4_no_upd", 32'(upd_done), 32'd0);
    sync_sig("t4_ovs_seen", 0, 100);
    wait_sig(0, 100, n);
    chk("t4_gap", 32'(n), 32'd12);

    // T5: disable mid-period, then re-enable
    step(5);
    enable = 1'b0;
    count_sig(0, 30, c);
    chk("t5_no_ticks", 32'(c), 32'd0);
    enable = 1'b1;
    wait_sig(0, 100, n);
    chk("t5_reenable_gap", 32'(n), 32'd13);

    // Disable while PEND applies the held divisor on that edge
    load_and_run(16'd8, 1'b0);
    step(1);
    cfg_valid = 1'b1;
    cfg_div   = 16'd20;
    step(1);
    cfg_valid = 1'b0;
    chk("t7_pend_rdy", 32'(cfg_ready), 32'd0);
    step(2);
    enable = 1'b0;
    step(1);
    chk("t7_off_upd", 32'(upd_done), 32'd1);
    chk("t7_off_cur", 32'(cur_div), 32'd20);
    chk("t7_off_rdy", 32'(cfg_ready), 32'd1);
    chk("t7_off_tick", 32'(tick_ovs), 32'd0);
    step(1);
    chk("t7_upd_single", 32'(upd_done), 32'd0);

    // T6: async reset while PEND discards the shadow
    load_and_run(16'd8, 1'b0);
    step(1);
    cfg_valid = 1'b1;
    cfg_div   = 16'd20;
    step(1);
    cfg_valid = 1'b0;
    chk("t6_pend_rdy", 32'(cfg_ready), 32'd0);
    chk("t6_pend_cur", 32'(cur_div), 32'd8);
    step(3);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    step(2);
    enable    = 1'b0;
    line_idle = 1'b1;
    rst       = 1'b1;
    count_sig(2, 20, c);
    chk("t6_no_upd", 32'(c), 32'd0);
    chk("t6_cur_after", 32'(cur_div), 32'd434);
    enable = 1'b1;
    wait_sig(0, 1000, n);
    chk("t6_default_gap", 32'(n), 32'd435);
    count_sig(2, 20, c);
    chk("t6_no_late_upd", 32'(c), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
